// File: rtl/peripheral_axi4_slave_sram.sv
// peripheral_axi4_slave_sram: AXI4 slave over a byte-strobed word SRAM with independent write/read FSMs.
// Define PERIPHERAL_AXI4_SLAVE_SRAM_RANGE_CHECK_EN to answer out-of-range beats with SLVERR.
module peripheral_axi4_slave_sram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  awid,
    input  logic [31:0] awadr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wrdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

`ifdef PERIPHERAL_AXI4_SLAVE_SRAM_RANGE_CHECK_EN
    localparam int WA = 30;
`else
    localparam int WA = AW;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    w_state_t w_st, w_nx;
    r_state_t r_st, r_nx;

    logic [31:0]   mem [DEPTH];
    logic [3:0]    w_id, w_len, w_beat, r_id, r_len, r_beat;
    logic [1:0]    w_burst, r_burst;
    logic [WA-1:0] w_wa, r_wa;
    logic          w_err;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          w_last, r_last, w_oor, r_oor, w_err_d;
    logic          awready_d, wready_d, bvalid_d, arready_d, rvalid_d, rlast_d;
    logic [3:0]    bid_d, rid_d;
    logic [1:0]    bresp_d, rresp_d;
    logic [31:0]   rdata_d;
    logic          unused_ok;

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign b_hs    = bvalid & bready;
    assign ar_hs   = arvalid & arready;
    assign r_hs    = rvalid & rready;
    assign w_last  = w_beat == w_len;
    assign r_last  = r_beat == r_len;
    assign w_err_d = w_hs & ((wlast != w_last) | w_oor);
    assign unused_ok = &{1'b0, wid, awsize, arsize, awadr, araddr};

`ifdef PERIPHERAL_AXI4_SLAVE_SRAM_RANGE_CHECK_EN
    assign w_oor = |w_wa[WA-1:AW];
    assign r_oor = |r_wa[WA-1:AW];
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_st    <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= 4'd0;
            bresp   <= 2'b00;
        end else begin
            w_st    <= w_nx;
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
            bid     <= bid_d;
            bresp   <= bresp_d;
        end
    end

    always_comb begin
        w_nx = aw_hs ? W_DATA : (w_hs && w_last) ? W_RESP : b_hs ? W_IDLE : w_st;
    end

    always_comb begin
        awready_d = w_nx == W_IDLE;
        wready_d  = w_nx == W_DATA;
        bvalid_d  = w_nx == W_RESP;
        bid_d     = bvalid_d ? w_id : 4'd0;
        bresp_d   = bvalid_d ? {w_err | w_err_d, 1'b0} : 2'b00;
    end

    // WRAP bursts are deliberately treated as INCR; FIXED and reserved hold the address
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            w_id    <= awid;
            w_wa    <= awadr[WA+1:2];
            w_len   <= awlen;
            w_burst <= awburst;
            w_beat  <= 4'd0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_beat <= w_beat + 4'd1;
            w_wa   <= (w_burst[0] ^ w_burst[1]) ? w_wa + WA'(1) : w_wa;
            w_err  <= w_err | w_err_d;
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < 4; i++)
            if (w_hs && !w_oor && !areset && wstrb[i])
                mem[w_wa[AW-1:0]][8*i +: 8] <= wrdata[8*i +: 8];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_st    <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= 4'd0;
            rresp   <= 2'b00;
            rdata   <= 32'd0;
        end else begin
            r_st    <= r_nx;
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rlast   <= rlast_d;
            rid     <= rid_d;
            rresp   <= rresp_d;
            rdata   <= rdata_d;
        end
    end

    always_comb begin
        r_nx = ar_hs ? R_FETCH : (r_st == R_FETCH) ? R_DATA : (r_hs && r_last) ? R_IDLE : r_hs ? R_FETCH : r_st;
    end

    // The fetch cycle samples the array before any same-cycle write lands, giving read-old-data
    always_comb begin
        arready_d = r_nx == R_IDLE;
        rvalid_d  = r_nx == R_DATA;
        rlast_d   = rvalid_d & r_last;
        rid_d     = (r_st == R_FETCH) ? r_id : rid;
        rresp_d   = (r_st == R_FETCH) ? {r_oor, 1'b0} : rresp;
        rdata_d   = (r_st == R_FETCH) ? (r_oor ? 32'd0 : mem[r_wa[AW-1:0]]) : rdata;
    end

    always_ff @(posedge aclk) begin
        if (ar_hs) begin
            r_id    <= arid;
            r_wa    <= araddr[WA+1:2];
            r_len   <= arlen;
            r_burst <= arburst;
            r_beat  <= 4'd0;
        end else if (r_hs) begin
            r_beat <= r_beat + 4'd1;
            r_wa   <= (r_burst[0] ^ r_burst[1]) ? r_wa + WA'(1) : r_wa;
        end
    end

endmodule

// File: tb/tb_peripheral_axi4_slave_sram.sv
// tb_peripheral_axi4_slave_sram: table vectors, directed corner sequences and random bursts against a word-array model.
module tb_peripheral_axi4_slave_sram;
    localparam int DEPTH = 256;
`ifdef PERIPHERAL_AXI4_SLAVE_SRAM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        aclk, areset;
    logic [3:0]  awid, awlen, wid, bid, arid, arlen, rid, wstrb;
    logic [31:0] awadr, wrdata, araddr, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, bresp, arburst, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    peripheral_axi4_slave_sram #(.DEPTH(DEPTH), .AW(8)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] mdl[DEPTH];
    logic [31:0] wd[16];
    logic [3:0]  ws[16];
    logic [31:0] rd[16];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no handshake, want one within 50 cycles", nm);
    endtask

    function automatic int unsigned full_wa(input logic [31:0] a, input logic [1:0] bu, input int b);
        return {2'b00, a[31:2]} + ((bu == 2'd1 || bu == 2'd2) ? 32'(b) : 32'd0);
    endfunction

    function automatic bit oor(input int unsigned f);
        return RC && f >= DEPTH;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [3:0] len, input logic [1:0] bu,
                            input int wl, input int nb, output logic [1:0] resp);
        int unsigned f;
        bit err;
        err = wl != int'(len);
        for (int b = 0; b < nb; b++) begin
            f = full_wa(a, bu, b);
            if (oor(f)) err = 1'b1;
            else for (int i = 0; i < 4; i++) if (ws[b][i]) mdl[f % DEPTH][8*i +: 8] = wd[b][8*i +: 8];
        end
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        @(posedge aclk); #1;
        chk("rst awready", 32'(awready), 0);
        chk("rst wready", 32'(wready), 0);
        chk("rst arready", 32'(arready), 0);
        chk("rst bvalid", 32'(bvalid), 0);
        chk("rst rvalid", 32'(rvalid), 0);
        chk("rst rlast", 32'(rlast), 0);
        chk("rst bid", 32'(bid), 0);
        chk("rst rid", 32'(rid), 0);
        chk("rst bresp", 32'(bresp), 0);
        chk("rst rresp", 32'(rresp), 0);
        chk("rst rdata", rdata, 0);
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("post-rst awready", 32'(awready), 1);
        chk("post-rst arready", 32'(arready), 1);
        chk("post-rst wready", 32'(wready), 0);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len, input logic [1:0] bu,
                            input int wl, input int abort_at, input int bhold, input logic [1:0] exp_resp);
        int n;
        awid = id; awadr = a; awlen = len; awburst = bu; awsize = 3'd2; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(posedge aclk); #1; n++; end
        if (!awready) begin awvalid = 1'b0; tmo("aw"); return; end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (b == abort_at) begin
                pulse_reset();
                repeat (3) begin @(posedge aclk); #1; chk("abort no bvalid", 32'(bvalid), 0); end
                return;
            end
            if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
            wvalid = 1'b1; wid = id; wrdata = wd[b]; wstrb = ws[b]; wlast = b == wl;
            n = 0;
            while (!wready && n < 50) begin @(posedge aclk); #1; n++; end
            if (!wready) begin wvalid = 1'b0; tmo("w"); return; end
            @(posedge aclk); #1;
            wvalid = 1'b0; wlast = 1'b0;
        end
        n = 0;
        while (!bvalid && n < 50) begin @(posedge aclk); #1; n++; end
        if (!bvalid) begin tmo("b"); return; end
        chk("bresp", 32'(bresp), 32'(exp_resp));
        chk("bid", 32'(bid), 32'(id));
        repeat (bhold) begin
            @(posedge aclk); #1;
            chk("bvalid hold", 32'(bvalid), 1);
            chk("bresp hold", 32'(bresp), 32'(exp_resp));
            chk("bid hold", 32'(bid), 32'(id));
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    // mode: 0 no stall, 1 rready low one cycle per beat, 2 random stalls
    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len, input logic [1:0] bu,
                           input int mode);
        int n;
        int unsigned f;
        logic [31:0] ed;
        logic [1:0] er;
        arid = id; araddr = a; arlen = len; arburst = bu; arsize = 3'd2; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(posedge aclk); #1; n++; end
        if (!arready) begin arvalid = 1'b0; tmo("ar"); return; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < 50) begin @(posedge aclk); #1; n++; end
            if (!rvalid) begin tmo("r"); return; end
            if (b == 0) chk("ar-to-rvalid cycles", 32'(n + 1), 2);
            f = full_wa(a, bu, b);
            ed = oor(f) ? 32'd0 : mdl[f % DEPTH];
            er = oor(f) ? 2'b10 : 2'b00;
            rd[b] = rdata;
            chk("rdata", rdata, ed);
            chk("rresp", 32'(rresp), 32'(er));
            chk("rlast", 32'(rlast), 32'(b == int'(len)));
            chk("rid", 32'(rid), 32'(id));
            n = mode == 1 ? 1 : mode == 2 ? int'($urandom_range(0, 2)) : 0;
            repeat (n) begin
                @(posedge aclk); #1;
                chk("rvalid stall", 32'(rvalid), 1);
                chk("rdata stall", rdata, ed);
                chk("rlast stall", 32'(rlast), 32'(b == int'(len)));
            end
            rready = 1'b1;
            @(posedge aclk); #1;
            rready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want test end within 500000 time units");
        $fatal(1);
    end

    initial begin
        logic [1:0]  er;
        logic [31:0] old, a;
        logic [3:0]  l, id;
        logic [1:0]  bu;
        int          wl;
        tbl[0] = '{32'h10,  32'hDEADBEEF, 4'hF, 32'h10,  32'hDEADBEEF};
        tbl[1] = '{32'h14,  32'h11223344, 4'hF, 32'h14,  32'h11223344};
        tbl[2] = '{32'h14,  32'hAABBCCDD, 4'h5, 32'h14,  32'h11BB33DD};
        tbl[3] = '{32'h14,  32'h00000000, 4'h0, 32'h14,  32'h11BB33DD};
        tbl[4] = '{32'h17,  32'hCAFEF00D, 4'hA, 32'h14,  32'hCABBF0DD};
        tbl[5] = '{32'h3FC, 32'h12345678, 4'hF, 32'h3FF, 32'h12345678};
        {awid, awadr, awlen, awsize, awburst, awvalid, wid, wrdata, wstrb, wlast, wvalid, bready} = '0;
        {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        pulse_reset();

        for (int k = 0; k < DEPTH / 16; k++) begin
            for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
            model_wr(32'(k * 64), 4'd15, 2'd1, 15, 16, er);
            do_write(4'(k), 32'(k * 64), 4'd15, 2'd1, 15, -1, 0, er);
        end

        for (int i = 0; i < 6; i++) begin
            wd[0] = tbl[i].wdata; ws[0] = tbl[i].strb;
            model_wr(tbl[i].waddr, 4'd0, 2'd1, 0, 1, er);
            do_write(4'(i + 3), tbl[i].waddr, 4'd0, 2'd1, 0, -1, 0, 2'b00);
            do_read(4'(i + 7), tbl[i].raddr, 4'd0, 2'd1, 0);
            chk("table rdata", rd[0], tbl[i].exp);
        end

        for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
        model_wr(32'h20, 4'd3, 2'd1, 3, 4, er);
        do_write(4'hA, 32'h20, 4'd3, 2'd1, 3, -1, 0, 2'b00);
        do_read(4'hB, 32'h20, 4'd3, 2'd1, 1);
        for (int b = 0; b < 4; b++) chk("incr burst data", rd[b], 32'(b + 1));

        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        model_wr(32'h40, 4'd2, 2'd0, 2, 3, er);
        do_write(4'h2, 32'h40, 4'd2, 2'd0, 2, -1, 0, 2'b00);
        do_read(4'h3, 32'h40, 4'd1, 2'd0, 0);
        chk("fixed burst last beat wins", rd[1], 32'hC);
        do_read(4'h4, 32'h44, 4'd0, 2'd1, 0);

        for (int b = 0; b < 4; b++) begin wd[b] = 32'hF00 + 32'(b); ws[b] = 4'hF; end
        model_wr(32'h3F8, 4'd3, 2'd1, 3, 4, er);
        do_write(4'h5, 32'h3F8, 4'd3, 2'd1, 3, -1, 0, RC ? 2'b10 : 2'b00);
        do_read(4'h6, 32'h3F8, 4'd3, 2'd2, 0);
        do_read(4'h7, 32'h0, 4'd1, 2'd1, 0);

        for (int b = 0; b < 4; b++) begin wd[b] = 32'h5000 + 32'(b); ws[b] = 4'hF; end
        model_wr(32'h60, 4'd3, 2'd1, 1, 4, er);
        do_write(4'hC, 32'h60, 4'd3, 2'd1, 1, -1, 5, 2'b10);
        do_read(4'hD, 32'h60, 4'd3, 2'd1, 0);

        for (int b = 0; b < 4; b++) begin wd[b] = 32'h7700 + 32'(b); ws[b] = 4'hF; end
        model_wr(32'h80, 4'd3, 2'd1, 3, 2, er);
        do_write(4'hE, 32'h80, 4'd3, 2'd1, 3, 2, 0, 2'b00);
        do_read(4'hF, 32'h80, 4'd3, 2'd1, 0);
        chk("abort beat0 kept", rd[0], 32'h7700);
        chk("abort beat1 kept", rd[1], 32'h7701);

        old = mdl[8];
        awid = 4'h3; awadr = 32'h20; awlen = 4'd0; awburst = 2'd1; awvalid = 1'b1;
        chk("same-cycle awready", 32'(awready), 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        chk("same-cycle wready", 32'(wready), 1);
        arid = 4'h5; araddr = 32'h20; arlen = 4'd0; arburst = 2'd1; arvalid = 1'b1;
        chk("same-cycle arready", 32'(arready), 1);
        @(posedge aclk); #1;
        arvalid = 1'b0; wvalid = 1'b1; wrdata = 32'h0BADF00D; wstrb = 4'hF; wlast = 1'b1;
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
        chk("same-cycle rvalid", 32'(rvalid), 1);
        chk("same-cycle old data", rdata, old);
        chk("same-cycle bvalid", 32'(bvalid), 1);
        rready = 1'b1; bready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0; bready = 1'b0;
        mdl[8] = 32'h0BADF00D;
        do_read(4'h6, 32'h20, 4'd0, 2'd1, 0);

        old = mdl[0];
        wd[0] = 32'h55AA55AA; ws[0] = 4'hF;
        model_wr(32'h400, 4'd0, 2'd1, 0, 1, er);
        do_write(4'h9, 32'h400, 4'd0, 2'd1, 0, -1, 0, RC ? 2'b10 : 2'b00);
        do_read(4'h1, 32'h0, 4'd0, 2'd1, 0);
        chk("0x400 write vs word 0", rd[0], RC ? old : 32'h55AA55AA);
        do_read(4'h2, 32'h400, 4'd0, 2'd1, 0);

        for (int t = 0; t < 60; t++) begin
            a = 32'($urandom_range(0, 'h7FF));
            l = 4'($urandom_range(0, 15));
            bu = 2'($urandom_range(0, 3));
            id = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
                wl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'(l);
                model_wr(a, l, bu, wl, int'(l) + 1, er);
                do_write(id, a, l, bu, wl, -1, int'($urandom_range(0, 2)), er);
            end else begin
                do_read(id, a, l, bu, 2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
